axi4lite_fifo_master: RTL and testbench

AXI4LITE_FIFO_MASTER -- requirements
Module: axi4lite_fifo_master

---
 rtl/axi4lite_fifo_master.sv | 182 ++++++++++++++++++
 tb/tb_axi4lite_fifo_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_fifo_master.sv
// AXI4-Lite master fed from a show-ahead-less source FIFO.
// Write path: pop one {addr,data} entry, issue AW/W, wait for B, repeat.
// Read path: independent single-outstanding read triggered by rd_req.
// err_count accumulates non-OKAY B/R responses and saturates.
module axi4lite_fifo_master #(
  parameter int ERR_W = 8
) (
  input  logic              aclk,
  input  logic              reset,
  // write address channel
  output logic [31:0]       awaddr,
  output logic              awvalid,
  input  logic              awready,
  // write data channel
  output logic [31:0]       wdata,
  output logic              wvalid,
  input  logic              wready,
  // write response channel
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // read address channel
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  // read data channel
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // source FIFO
  output logic              fifo_rd_en,
  input  logic [63:0]       fifo_rd_data,
  input  logic              fifo_empty,
  // read command / result
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [31:0]       rd_result,
  output logic [1:0]        rd_status,
  // error statistics
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FETCH = 2'd1,
    W_ADDR  = 2'd2,
    W_RESP  = 2'd3
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  // Error events are qualified by the FSM state so only accepted
  // responses count (bready/rready are high exactly in those states).
  logic             wr_err_evt;
  logic             rd_err_evt;
  logic [1:0]       err_inc;
  logic [ERR_W:0]   err_sum;

  assign wr_err_evt = (w_state == W_RESP) && bvalid && (bresp != 2'b00);
  assign rd_err_evt = (r_state == R_DATA) && rvalid && (rresp != 2'b00);
  assign err_inc    = {1'b0, wr_err_evt} + {1'b0, rd_err_evt};
  assign err_sum    = {1'b0, err_count} + {{(ERR_W-1){1'b0}}, err_inc};

  // Write FSM: pop, fetch, AW/W handshakes, B response; one write in flight.
  // fifo_rd_en is registered, so it is high during the first W_FETCH cycle
  // and the entry only appears on fifo_rd_data one cycle later; W_FETCH
  // therefore spends one cycle dropping the strobe and one latching data.
  always_ff @(posedge aclk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      fifo_rd_en <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      awaddr     <= 32'h0;
      wdata      <= 32'h0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
            w_state    <= W_FETCH;
          end
        end
        W_FETCH: begin
          if (fifo_rd_en) begin
            fifo_rd_en <= 1'b0;
          end else begin
            awaddr  <= fifo_rd_data[63:32];
            wdata   <= fifo_rd_data[31:0];
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            w_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          // AW and W complete independently; leave once both are done,
          // counting a handshake happening on this very edge.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept rd_req only when idle, AR handshake, then R beat.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      araddr    <= 32'h0;
      rd_result <= 32'h0;
      rd_status <= 2'b00;
    end else begin
      rd_done <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rd_req) begin
            araddr  <= rd_addr;
            arvalid <= 1'b1;
            rd_busy <= 1'b1;
            r_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rd_result <= rdata;
            rd_status <= rresp;
            rd_done   <= 1'b1;
            rd_busy   <= 1'b0;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Saturating error counter; carry out of the add means clamp to all-ones.
  always_ff @(posedge aclk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_sum[ERR_W]) begin
      err_count <= '1;
    end else begin
      err_count <= err_sum[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_axi4lite_fifo_master.sv
// Bench for axi4lite_fifo_master: randomized AXI slave + source FIFO,
// transaction-level reference model checked every cycle, directed scenarios.
module tb_axi4lite_fifo_master;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int SRC_N   = 512;

  logic              aclk, reset;
  logic [31:0]       awaddr, wdata, araddr, rdata, rd_addr, rd_result;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [1:0]        bresp, rresp, rd_status;
  logic              fifo_rd_en, fifo_empty, rd_req, rd_busy, rd_done;
  logic [63:0]       fifo_rd_data;
  logic [ERR_W-1:0]  err_count;

  axi4lite_fifo_master #(.ERR_W(ERR_W)) dut (
    .aclk(aclk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_result(rd_result), .rd_status(rd_status), .err_count(err_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0, n_err = 0;

  // source FIFO contents (written by stimulus, consumed on pop strobes)
  logic [63:0] src [SRC_N];
  int          src_wr = 0, src_rd = 0;

  // slave behaviour knobs (percent probabilities)
  int unsigned p_aw = 100, p_w = 100, p_b = 100, p_ar = 100, p_r = 100;
  int unsigned p_berr = 0, p_rerr = 0;
  logic        r_force = 1'b0;
  logic [31:0] r_fdata = 32'h0;
  logic [1:0]  r_fresp = 2'b00;

  // reference model state
  logic        wr_busy, aw_seen, w_seen, idle_ok, rd_out, ar_seen;
  int          pop_age;
  logic [63:0] cur_entry = 64'h0;
  logic [31:0] exp_raddr, exp_res;
  logic [1:0]  exp_st;
  int          exp_err;
  int          n_pop = 0, n_wr = 0, n_rdone = 0;

  // values in force across the edge just passed
  logic        p_reset = 1'b1;
  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic        p_arvalid, p_arready, p_rvalid, p_rready, p_rd_req, p_fifo_empty;
  logic [1:0]  p_bresp, p_rresp;
  logic [31:0] p_rdata, p_rd_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One negedge: retire the events of the previous edge into the model,
  // compare every DUT output, then act as FIFO and slave for the next edge.
  task automatic step();
    logic exp_pop, acc_rd, done_now;
    int   inc;
    if (p_reset) begin
      wr_busy = 0; aw_seen = 0; w_seen = 0; pop_age = 0; idle_ok = 1;
      rd_out = 0; ar_seen = 0; exp_raddr = 0; exp_res = 0; exp_st = 0; exp_err = 0;
      bvalid = 0; rvalid = 0;
      chk("rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, fifo_rd_en, rd_done, rd_busy}), 64'h0);
      chk("rst_wr_regs", {awaddr, wdata}, 64'h0);
      chk("rst_rd_regs", {araddr, rd_result}, 64'h0);
      chk("rst_status_err", 64'({rd_status, err_count}), 64'h0);
    end else begin
      exp_pop  = idle_ok && !p_fifo_empty;
      acc_rd   = p_rd_req && !rd_out;
      done_now = 0;
      inc      = 0;
      if (wr_busy) pop_age++;
      if (p_awvalid && p_awready) aw_seen = 1;
      if (p_wvalid && p_wready) w_seen = 1;
      if (p_bvalid && p_bready) begin
        wr_busy = 0; aw_seen = 0; w_seen = 0; idle_ok = 1; bvalid = 0; n_wr++;
        if (p_bresp != 2'b00) inc++;
      end
      if (p_arvalid && p_arready) ar_seen = 1;
      if (p_rvalid && p_rready) begin
        rd_out = 0; ar_seen = 0; rvalid = 0; done_now = 1;
        exp_res = p_rdata; exp_st = p_rresp;
        if (p_rresp != 2'b00) inc++;
      end
      if (acc_rd) begin
        rd_out = 1; exp_raddr = p_rd_addr;
      end
      exp_err = (exp_err + inc > ERR_MAX) ? ERR_MAX : exp_err + inc;

      chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_pop));
      chk("awvalid", 64'(awvalid), 64'(wr_busy && !aw_seen && pop_age >= 2));
      chk("wvalid", 64'(wvalid), 64'(wr_busy && !w_seen && pop_age >= 2));
      if (awvalid) chk("awaddr", 64'(awaddr), 64'(cur_entry[63:32]));
      if (wvalid) chk("wdata", 64'(wdata), 64'(cur_entry[31:0]));
      chk("bready", 64'(bready), 64'(wr_busy && aw_seen && w_seen));
      chk("rd_busy", 64'(rd_busy), 64'(rd_out));
      chk("arvalid", 64'(arvalid), 64'(rd_out && !ar_seen));
      chk("rready", 64'(rready), 64'(rd_out && ar_seen));
      chk("araddr", 64'(araddr), 64'(exp_raddr));
      chk("rd_done", 64'(rd_done), 64'(done_now));
      chk("rd_result", 64'(rd_result), 64'(exp_res));
      chk("rd_status", 64'(rd_status), 64'(exp_st));
      chk("err_count", 64'(err_count), 64'(exp_err));

      if (fifo_rd_en) begin
        cur_entry = (src_rd != src_wr) ? src[src_rd] : 64'h0;
        if (src_rd != src_wr) src_rd++;
        fifo_rd_data = cur_entry;
        wr_busy = 1; aw_seen = 0; w_seen = 0; pop_age = 0; idle_ok = 0; n_pop++;
      end
      if (rd_done) n_rdone++;
      if (!bvalid && wr_busy && aw_seen && w_seen && $urandom_range(99, 0) < p_b) begin
        bvalid = 1;
        bresp  = ($urandom_range(99, 0) < p_berr) ? 2'($urandom_range(3, 1)) : 2'b00;
      end
      if (!rvalid && rd_out && ar_seen && $urandom_range(99, 0) < p_r) begin
        rvalid = 1;
        rdata  = r_force ? r_fdata : $urandom;
        rresp  = r_force ? r_fresp :
                 (($urandom_range(99, 0) < p_rerr) ? 2'($urandom_range(3, 1)) : 2'b00);
      end
    end
    awready    = ($urandom_range(99, 0) < p_aw);
    wready     = ($urandom_range(99, 0) < p_w);
    arready    = ($urandom_range(99, 0) < p_ar);
    fifo_empty = (src_rd == src_wr);

    p_reset = reset; p_rd_req = rd_req; p_rd_addr = rd_addr; p_fifo_empty = fifo_empty;
    p_awvalid = awvalid; p_awready = awready; p_wvalid = wvalid; p_wready = wready;
    p_bvalid = bvalid; p_bready = bready; p_bresp = bresp;
    p_arvalid = arvalid; p_arready = arready;
    p_rvalid = rvalid; p_rready = rready; p_rdata = rdata; p_rresp = rresp;
  endtask

  task automatic tick();
    @(negedge aclk);
    step();
    @(posedge aclk);
    #2;
  endtask

  task automatic push(input logic [63:0] e);
    if (src_wr < SRC_N) begin
      src[src_wr] = e;
      src_wr++;
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    rd_req = 1; rd_addr = a;
    tick();
    rd_req = 0;
    tick();
    for (int i = 0; i < 40 && rd_out; i++) tick();
    chk("read_complete", 64'(rd_out), 64'h0);
  endtask

  initial begin
    int n0, w0, d0;
    reset = 1; rd_req = 0; rd_addr = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
    rvalid = 0; rdata = 0; rresp = 0; fifo_empty = 1; fifo_rd_data = 0;

    // reset state
    repeat (3) tick();
    chk("reset_valids", 64'({awvalid, wvalid, bready, arvalid, rready, fifo_rd_en, rd_done, rd_busy}), 64'h0);
    chk("reset_addrs", {awaddr, araddr}, 64'h0);
    chk("reset_wdata_res", {wdata, rd_result}, 64'h0);
    chk("reset_err", 64'({rd_status, err_count}), 64'h0);
    reset = 0;
    repeat (2) tick();

    // single write, AW and W accepted together, OKAY response
    push({32'h0000_0010, 32'hDEAD_BEEF});
    for (int i = 0; i < 50 && n_wr < 1; i++) tick();
    repeat (4) tick();
    chk("s1_writes", 64'(n_wr), 64'd1);
    chk("s1_pops", 64'(n_pop), 64'd1);
    chk("s1_awaddr", 64'(awaddr), 64'h10);
    chk("s1_wdata", 64'(wdata), 64'hDEAD_BEEF);
    chk("s1_err", 64'(err_count), 64'd0);

    // W accepted well before AW
    p_aw = 0;
    push({32'h0000_0abc, 32'h5555_aaaa});
    for (int i = 0; i < 20 && !w_seen; i++) tick();
    repeat (3) tick();
    chk("s2_awvalid_hold", 64'(awvalid), 64'd1);
    chk("s2_wvalid_drop", 64'(wvalid), 64'd0);
    chk("s2_awaddr_stable", 64'(awaddr), 64'h0abc);
    chk("s2_bready_wait", 64'(bready), 64'd0);
    p_aw = 100;
    for (int i = 0; i < 30 && n_wr < 2; i++) tick();
    chk("s2_writes", 64'(n_wr), 64'd2);

    // read with SLVERR
    d0 = n_rdone;
    r_force = 1; r_fdata = 32'h1234_5678; r_fresp = 2'b10;
    do_read(32'h24);
    tick();
    chk("s3_done_once", 64'(n_rdone - d0), 64'd1);
    chk("s3_result", 64'(rd_result), 64'h1234_5678);
    chk("s3_status", 64'(rd_status), 64'h2);
    chk("s3_err", 64'(err_count), 64'd1);
    r_force = 0;

    // rd_req while busy is ignored
    p_ar = 0;
    rd_req = 1; rd_addr = 32'h100;
    tick();
    rd_req = 0;
    repeat (2) tick();
    rd_req = 1; rd_addr = 32'h200;
    tick();
    rd_req = 0;
    tick();
    chk("s4_araddr_kept", 64'(araddr), 64'h100);
    chk("s4_busy", 64'(rd_busy), 64'd1);
    p_ar = 100;
    for (int i = 0; i < 30 && rd_out; i++) tick();
    repeat (3) tick();
    chk("s4_no_second_read", 64'(rd_busy), 64'd0);
    chk("s4_araddr_final", 64'(araddr), 64'h100);

    // reset while AW is pending
    p_aw = 0; p_w = 0;
    n0 = n_pop; w0 = n_wr;
    push({32'h0000_1000, 32'h1111_1111});
    push({32'h0000_2000, 32'h2222_2222});
    for (int i = 0; i < 20 && !awvalid; i++) tick();
    chk("s5_in_addr", 64'(awvalid), 64'd1);
    reset = 1;
    tick();
    chk("s5_valids_dropped", 64'({awvalid, wvalid, bready, arvalid, rready, fifo_rd_en}), 64'h0);
    reset = 0;
    p_aw = 100; p_w = 100;
    for (int i = 0; i < 40 && n_wr < w0 + 1; i++) tick();
    repeat (4) tick();
    chk("s5_pops", 64'(n_pop - n0), 64'd2);
    chk("s5_writes", 64'(n_wr - w0), 64'd1);
    chk("s5_awaddr", 64'(awaddr), 64'h2000);

    // randomized concurrent traffic
    p_berr = 30; p_rerr = 30;
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        p_aw = $urandom_range(100, 20); p_w = $urandom_range(100, 20);
        p_b  = $urandom_range(100, 20); p_ar = $urandom_range(100, 20);
        p_r  = $urandom_range(100, 20);
      end
      if ($urandom_range(99, 0) < 20 && src_wr - src_rd < 8) push({$urandom, $urandom});
      rd_req  = ($urandom_range(99, 0) < 15);
      rd_addr = $urandom;
      tick();
    end
    rd_req = 0;
    p_aw = 100; p_w = 100; p_b = 100; p_ar = 100; p_r = 100; p_berr = 0; p_rerr = 0;
    for (int i = 0; i < 400 && !(src_rd == src_wr && !wr_busy && !rd_out); i++) tick();
    chk("rand_drained", 64'(src_rd == src_wr && !wr_busy && !rd_out), 64'd1);

    // saturation: climb to ERR_MAX-1 with erroring reads, then two at once
    p_rerr = 100;
    for (int k = 0; k < 300 && exp_err < ERR_MAX - 1; k++) do_read($urandom);
    tick();
    chk("s7_err_fe", 64'(err_count), 64'(ERR_MAX - 1));
    p_b = 0; p_r = 0; p_berr = 100;
    push({32'h0000_3000, 32'h3333_3333});
    rd_req = 1; rd_addr = 32'h3004;
    tick();
    rd_req = 0;
    for (int i = 0; i < 30 && !(bready && rready); i++) tick();
    chk("s7_both_waiting", 64'(bready && rready), 64'd1);
    p_b = 100; p_r = 100;
    tick();
    chk("s7_err_ff", 64'(err_count), 64'(ERR_MAX));
    do_read(32'h3008);
    tick();
    chk("s7_err_sat", 64'(err_count), 64'(ERR_MAX));
    push({32'h0000_4000, 32'h4444_4444});
    for (int i = 0; i < 40 && !(src_rd == src_wr && !wr_busy); i++) tick();
    tick();
    chk("s7_err_sat_wr", 64'(err_count), 64'(ERR_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
